// File: rtl/turn_ctrl.sv
// Turn sequencer for the cat-vs-dog artillery game: alternates players, charges the
// power meter, launches shots, resolves hits against the opponent box and tracks HP.
module turn_ctrl #(
  parameter int unsigned POWER_MAX       = 200,
  parameter int unsigned POWER_STEP      = 2,
  parameter int unsigned HP_MAX          = 100,
  parameter int unsigned DAMAGE          = 20,
  parameter int unsigned P1_XMIN         = 113,
  parameter int unsigned P2_XMIN         = 763,
  parameter int unsigned TARGET_W        = 128,
  parameter int unsigned FLIGHT_TIMEOUT  = 255,
  parameter int unsigned COOLDOWN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_p1,
  input  logic        btn_p2,
  input  logic        restart,
  input  logic        shot_done,
  input  logic [10:0] land_x,
  output logic        turn,
  output logic [7:0]  power,
  output logic        shot_start,
  output logic [7:0]  shot_power,
  output logic [6:0]  hp_p1,
  output logic [6:0]  hp_p2,
  output logic        busy,
  output logic        game_over,
  output logic        winner
);

  localparam int unsigned PWR_W   = 8;
  localparam int unsigned SUM_W   = PWR_W + 1;
  localparam int unsigned HP_W    = 7;
  localparam int unsigned X_W     = 11;
  localparam int unsigned XT_W    = X_W + 1;
  localparam int unsigned CNT_MAX = (FLIGHT_TIMEOUT > COOLDOWN_FRAMES) ? FLIGHT_TIMEOUT
                                                                       : COOLDOWN_FRAMES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_AIM,
    S_CHARGE,
    S_FLIGHT,
    S_RESOLVE,
    S_COOLDOWN,
    S_OVER
  } state_e;

  state_e             state_q, state_d;
  logic               turn_q, turn_d;
  logic [PWR_W-1:0]   power_q, power_d;
  logic               shot_start_q, shot_start_d;
  logic [PWR_W-1:0]   shot_power_q, shot_power_d;
  logic [HP_W-1:0]    hp_p1_q, hp_p1_d;
  logic [HP_W-1:0]    hp_p2_q, hp_p2_d;
  logic               busy_q, busy_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [X_W-1:0]     land_x_q, land_x_d;
  logic               timeout_q, timeout_d;

  logic               btn_act;
  logic [SUM_W-1:0]   power_sum;
  logic [PWR_W-1:0]   power_sat;
  logic [CNT_W-1:0]   cnt_inc;
  logic [XT_W-1:0]    tgt_lo;
  logic [XT_W-1:0]    tgt_hi;
  logic [XT_W-1:0]    land_ext;
  logic               hit;
  logic [HP_W-1:0]    opp_hp;
  logic [HP_W-1:0]    hp_after;

  // Datapath helpers: active button, saturated power, hit test against opponent box
  always_comb begin
    btn_act   = turn_q ? btn_p1 : btn_p2;
    power_sum = {1'b0, power_q} + SUM_W'(POWER_STEP);
    power_sat = (power_sum > SUM_W'(POWER_MAX)) ? PWR_W'(POWER_MAX) : power_sum[PWR_W-1:0];
    cnt_inc   = cnt_q + CNT_W'(1);
    tgt_lo    = turn_q ? XT_W'(P2_XMIN) : XT_W'(P1_XMIN);
    tgt_hi    = turn_q ? XT_W'(P2_XMIN + TARGET_W - 1) : XT_W'(P1_XMIN + TARGET_W - 1);
    land_ext  = {1'b0, land_x_q};
    hit       = !timeout_q && (land_ext >= tgt_lo) && (land_ext <= tgt_hi);
    opp_hp    = turn_q ? hp_p2_q : hp_p1_q;
    if (!hit) begin
      hp_after = opp_hp;
    end else if (opp_hp > HP_W'(DAMAGE)) begin
      hp_after = opp_hp - HP_W'(DAMAGE);
    end else begin
      hp_after = '0;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    turn_d       = turn_q;
    power_d      = power_q;
    shot_start_d = 1'b0;
    shot_power_d = shot_power_q;
    hp_p1_d      = hp_p1_q;
    hp_p2_d      = hp_p2_q;
    winner_d     = winner_q;
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    land_x_d     = land_x_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      S_AIM: begin
        power_d = '0;
        if (armed_q && btn_act) begin
          state_d = S_CHARGE;
        end else if (!btn_act) begin
          armed_d = 1'b1;
        end
      end

      // Release takes priority over a coincident frame tick
      S_CHARGE: begin
        if (!btn_act) begin
          if (power_q == '0) begin
            state_d = S_AIM;
            armed_d = 1'b0;
          end else begin
            shot_start_d = 1'b1;
            shot_power_d = power_q;
            cnt_d        = '0;
            timeout_d    = 1'b0;
            state_d      = S_FLIGHT;
          end
        end else if (frame_tick) begin
          power_d = power_sat;
        end
      end

      S_FLIGHT: begin
        if (shot_done) begin
          land_x_d  = land_x;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_RESOLVE;
        end else if (frame_tick) begin
          if (cnt_inc == CNT_W'(FLIGHT_TIMEOUT)) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_RESOLVE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_RESOLVE: begin
        if (turn_q) begin
          hp_p2_d = hp_after;
        end else begin
          hp_p1_d = hp_after;
        end
        cnt_d = '0;
        if (hp_after == '0) begin
          winner_d = turn_q;
          state_d  = S_OVER;
        end else begin
          state_d = S_COOLDOWN;
        end
      end

      S_COOLDOWN: begin
        if (frame_tick) begin
          if (cnt_inc == CNT_W'(COOLDOWN_FRAMES)) begin
            cnt_d   = '0;
            turn_d  = ~turn_q;
            power_d = '0;
            armed_d = 1'b0;
            state_d = S_AIM;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_OVER: begin
        if (restart) begin
          hp_p1_d  = HP_W'(HP_MAX);
          hp_p2_d  = HP_W'(HP_MAX);
          turn_d   = 1'b1;
          power_d  = '0;
          winner_d = 1'b0;
          armed_d  = 1'b0;
          cnt_d    = '0;
          state_d  = S_AIM;
        end
      end

      default: begin
        state_d = S_AIM;
      end
    endcase

    busy_d      = (state_d == S_FLIGHT) || (state_d == S_RESOLVE) || (state_d == S_COOLDOWN);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_AIM;
      turn_q       <= 1'b1;
      power_q      <= '0;
      shot_start_q <= 1'b0;
      shot_power_q <= '0;
      hp_p1_q      <= HP_W'(HP_MAX);
      hp_p2_q      <= HP_W'(HP_MAX);
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      land_x_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      turn_q       <= turn_d;
      power_q      <= power_d;
      shot_start_q <= shot_start_d;
      shot_power_q <= shot_power_d;
      hp_p1_q      <= hp_p1_d;
      hp_p2_q      <= hp_p2_d;
      busy_q       <= busy_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      land_x_q     <= land_x_d;
      timeout_q    <= timeout_d;
    end
  end

  assign turn       = turn_q;
  assign power      = power_q;
  assign shot_start = shot_start_q;
  assign shot_power = shot_power_q;
  assign hp_p1      = hp_p1_q;
  assign hp_p2      = hp_p2_q;
  assign busy       = busy_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule
